inst_mem_responder: RTL

- Responder end of the core's instruction-fetch interface. Samples `inst_addr`/`inst_ena` from the fetch stage and returns a 32-bit `inst` after a programmable number of wait states.
- `inst_valid` drives the fetch stage's stall input, as `stall = ~inst_valid`.
- Holds a word-addressed instruction store. A separate load port lets the bench or boot logic write programs into it.

---
 rtl/inst_mem_pkg.sv | 23 ++
 rtl/inst_mem_array.sv | 26 ++
 rtl/inst_mem_responder.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/inst_mem_pkg.sv
// Types and constants shared by the instruction- and data-memory responders.
package inst_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } mem_state_e;

  localparam logic [31:0] DEFAULT_NOP_INST  = 32'h0000_0013;
  localparam logic [63:0] DEFAULT_BASE_ADDR = 64'h0000_0000_8000_0000;

  typedef struct packed {
    logic [63:0] addr;
    logic        misaligned;
    logic        out_of_range;
  } mem_req_t;

  function automatic logic req_fault(input mem_req_t r);
    return r.misaligned | r.out_of_range;
  endfunction

endpackage

// File: rtl/inst_mem_array.sv
// DEPTH x 32 instruction store: one registered read port, one write port.
// A read and write to the same word on one edge returns the old word.
module inst_mem_array #(
  parameter int DEPTH = 1024
) (
  input  logic                     clk,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [31:0]              rd_data,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [31:0]              wr_data
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/inst_mem_responder.sv
// Instruction-fetch responder returning words after WAIT_CYCLES wait states.
// Define INST_MEM_LAST_HIT_EN to add a one-entry last-hit buffer and the hit output.
module inst_mem_responder
  import inst_mem_pkg::*;
#(
  parameter int          DEPTH       = 1024,
  parameter logic [63:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] NOP_INST    = DEFAULT_NOP_INST
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [63:0]              inst_addr,
  input  logic                     inst_ena,
  output logic [31:0]              inst,
  output logic                     inst_valid,
  output logic                     inst_fault,
  output logic                     busy,
  input  logic                     load_en,
  input  logic [$clog2(DEPTH)-1:0] load_addr,
  input  logic [31:0]              load_data
`ifdef INST_MEM_LAST_HIT_EN
  ,
  output logic                     hit
`endif
);

  localparam int         AW        = $clog2(DEPTH);
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_WAIT = WAIT;
  localparam logic [1:0] ST_RESP = RESP;

  // Which registered source currently drives inst.
  localparam logic [1:0] SRC_ZERO = 2'd0;
  localparam logic [1:0] SRC_RAM  = 2'd1;
  localparam logic [1:0] SRC_NOP  = 2'd2;
  localparam logic [1:0] SRC_TAG  = 2'd3;

  logic [1:0]    state_reg;
  logic [3:0]    count_reg;
  mem_req_t      req_reg;
  logic [1:0]    src_reg;
  logic [31:0]   ram_q;

  mem_req_t      live_req;
  logic [63:0]   offset;
  logic [63:0]   req_offset;
  logic [AW-1:0] index;
  logic [AW-1:0] req_index;
  logic [AW-1:0] rd_addr;
  logic          in_wait;
  logic          accept;
  logic          tag_hit;
  logic          rd_now;
  logic          rd_fault;
  logic          rd_en;

  assign offset     = inst_addr - BASE_ADDR;
  assign index      = AW'(offset >> 2);
  assign req_offset = req_reg.addr - BASE_ADDR;
  assign req_index  = AW'(req_offset >> 2);

  always_comb begin
    live_req              = '0;
    live_req.addr         = inst_addr;
    live_req.misaligned   = |inst_addr[1:0];
    live_req.out_of_range = (inst_addr < BASE_ADDR) || ((offset >> 2) >= 64'(DEPTH));
  end

  assign in_wait = (state_reg == ST_WAIT);
  assign accept  = inst_ena && ((state_reg == ST_IDLE) || (state_reg == ST_RESP));

  // The array is read on the last wait edge, or on the accept edge when there are no wait states.
  assign rd_now   = (in_wait && (count_reg == 4'd1)) || (accept && !tag_hit && (WAIT_CYCLES == 0));
  assign rd_fault = in_wait ? req_fault(req_reg) : req_fault(live_req);
  assign rd_en    = rd_now && !rd_fault;
  assign rd_addr  = in_wait ? req_index : index;

  inst_mem_array #(
    .DEPTH(DEPTH)
  ) u_array (
    .clk    (clk),
    .rd_en  (rd_en),
    .rd_addr(rd_addr),
    .rd_data(ram_q),
    .wr_en  (load_en),
    .wr_addr(load_addr),
    .wr_data(load_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= ST_IDLE;
      count_reg  <= '0;
      req_reg    <= '0;
      src_reg    <= SRC_ZERO;
      inst_valid <= 1'b0;
      inst_fault <= 1'b0;
      busy       <= 1'b0;
    end else begin
      inst_valid <= 1'b0;
      if (in_wait) begin
        count_reg <= count_reg - 4'd1;
        if (count_reg == 4'd1) begin
          state_reg  <= ST_RESP;
          inst_valid <= 1'b1;
          inst_fault <= rd_fault;
          src_reg    <= rd_fault ? SRC_NOP : SRC_RAM;
        end
      end else if (accept) begin
        req_reg <= live_req;
        busy    <= 1'b1;
        if (tag_hit) begin
          state_reg  <= ST_RESP;
          inst_valid <= 1'b1;
          inst_fault <= 1'b0;
          src_reg    <= SRC_TAG;
        end else if (WAIT_CYCLES == 0) begin
          state_reg  <= ST_RESP;
          inst_valid <= 1'b1;
          inst_fault <= rd_fault;
          src_reg    <= rd_fault ? SRC_NOP : SRC_RAM;
        end else begin
          state_reg <= ST_WAIT;
          count_reg <= WAIT_INIT;
        end
      end else begin
        state_reg <= ST_IDLE;
        busy      <= 1'b0;
      end
    end
  end

`ifdef INST_MEM_LAST_HIT_EN
  logic          tag_valid_reg;
  logic          stale_reg;
  logic [AW-1:0] tag_index_reg;
  logic [31:0]   tag_data_reg;
  logic          capture;

  assign tag_hit = accept && tag_valid_reg && !req_fault(live_req) && (index == tag_index_reg);

  // The RAM word lands one cycle after the read, so the tag is filled during RESP;
  // a load racing the read makes that word stale and it is not buffered.
  assign capture = (state_reg == ST_RESP) && (src_reg == SRC_RAM) && !stale_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag_valid_reg <= 1'b0;
      stale_reg     <= 1'b0;
      tag_index_reg <= '0;
      tag_data_reg  <= '0;
      hit           <= 1'b0;
    end else begin
      hit <= tag_hit;
      if (rd_now) begin
        stale_reg <= load_en && (load_addr == rd_addr);
      end
      if (capture) begin
        tag_index_reg <= req_index;
        tag_data_reg  <= ram_q;
        tag_valid_reg <= !(load_en && (load_addr == req_index));
      end else if (load_en && (load_addr == tag_index_reg)) begin
        tag_valid_reg <= 1'b0;
      end
      if (accept && req_fault(live_req)) begin
        tag_valid_reg <= 1'b0;
      end
    end
  end
`else
  assign tag_hit = 1'b0;
`endif

  always_comb begin
    case (src_reg)
      SRC_RAM: inst = ram_q;
      SRC_NOP: inst = NOP_INST;
`ifdef INST_MEM_LAST_HIT_EN
      SRC_TAG: inst = tag_data_reg;
`else
      SRC_TAG: inst = 32'h0;
`endif
      default: inst = 32'h0;
    endcase
  end

endmodule
